// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle main-control FSM: state encodings,
// opcode values and ALU operation selectors.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 7;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_ADDR    = 4'd3,
      S_MEM_RD  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_WB_R    = 4'd6,
      S_WB_MEM  = 4'd7,
      S_BRANCH  = 4'd8,
      S_ILLEGAL = 4'd9
   } state_t;

   localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'd0;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'd1;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'd2;

   // States whose exit into FETCH completes an instruction.
   function automatic logic is_retire_state(input state_t s);
      return (s == S_WB_R) || (s == S_WB_MEM) || (s == S_MEM_WR) || (s == S_BRANCH);
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore main-control FSM for a multicycle datapath with sticky illegal-opcode flag.
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_src,
   output logic               ir_write,
   output logic               i_or_d,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               MemToReg,
   output logic               ALUSrc,
   output logic               Branch,
   output logic [ALUOP_W-1:0] ALUop,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   retired
);

   state_t state_q;
   state_t state_d;
   logic   illegal_q;
   logic   is_store_q;

   // State register plus flags captured alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         illegal_q  <= 1'b0;
         is_store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ILLEGAL) illegal_q  <= 1'b1;
         if (state_q == S_DECODE)  is_store_q <= opcode[5];
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_d  = state_q;
      pc_write = 1'b0;
      pc_src   = 1'b0;
      ir_write = 1'b0;
      i_or_d   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      ALUSrc   = 1'b0;
      Branch   = 1'b0;
      ALUop    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R:               state_d = S_EXEC_R;
               OP_LOAD, OP_STORE:  state_d = S_ADDR;
               OP_BRANCH:          state_d = S_BRANCH;
               default:            state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            ALUop   = ALUOP_FUNCT;
            state_d = S_WB_R;
         end
         S_WB_R: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_ADDR: begin
            ALUop   = ALUOP_ADD;
            ALUSrc  = 1'b1;
            state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) state_d = S_WB_MEM;
         end
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUop    = ALUOP_SUB;
            Branch   = 1'b1;
            pc_src   = 1'b1;
            pc_write = zero;
            state_d  = S_FETCH;
         end
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase
   end

   assign illegal = illegal_q;
   assign state_o = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [CNT_W-1:0] retired_q;

   // Count instructions as they hand control back to FETCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
      end else if (state_d == S_FETCH && is_retire_state(state_q)) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// instruction sequences and a randomized instruction-level reference model.
module tb_multicycle_ctrl;

   localparam logic [6:0] C_R   = 7'b0110011;
   localparam logic [6:0] C_LD  = 7'b0000011;
   localparam logic [6:0] C_ST  = 7'b0100011;
   localparam logic [6:0] C_BR  = 7'b1100011;
   localparam logic [6:0] C_BAD = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_src, ir_write, i_or_d, MemRead, MemWrite;
   logic        RegWrite, MemToReg, ALUSrc, Branch, illegal;
   logic [1:0]  ALUop;
   logic [3:0]  state_o;
   logic [31:0] retired;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_ret;

   typedef struct {
      string       name;
      logic        rst;
      logic [6:0]  op;
      logic        z;
      logic        mr;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Branch(Branch), .ALUop(ALUop),
      .illegal(illegal), .state_o(state_o), .retired(retired)
   );

   // Expected control word for a state, straight from the per-state output list.
   function automatic logic [16:0] ctl(int st, logic mr, logic z, logic ill);
      logic mrd, mwr, iod, irw, pcw, pcs, rw, m2r, asrc, br;
      logic [1:0] aop;
      {mrd, mwr, iod, irw, pcw, pcs, rw, m2r, asrc, br} = '0;
      aop = 2'd0;
      case (st)
         0: begin mrd = 1'b1; irw = mr; pcw = mr; end
         2: aop = 2'd2;
         3: begin asrc = 1'b1; aop = 2'd0; end
         4: begin mrd = 1'b1; iod = 1'b1; end
         5: begin mwr = 1'b1; iod = 1'b1; end
         6: rw = 1'b1;
         7: begin rw = 1'b1; m2r = 1'b1; end
         8: begin aop = 2'd1; br = 1'b1; pcs = 1'b1; pcw = z; end
         default: ;
      endcase
      return {4'(st), mrd, mwr, iod, irw, pcw, pcs, rw, m2r, asrc, br, aop, ill};
   endfunction

   function automatic logic [16:0] dut_word();
      return {state_o, MemRead, MemWrite, i_or_d, ir_write, pc_write, pc_src,
              RegWrite, MemToReg, ALUSrc, Branch, ALUop, illegal};
   endfunction

   function automatic logic [31:0] exp_ret(logic [31:0] m);
`ifdef MULTICYCLE_CTRL_PERF_EN
      return m;
`else
      return (m & 32'd0);
`endif
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, compare combinational outputs 1 ns later.
   task automatic cyc_exp(string name, logic r, logic [6:0] op, logic z, logic mr,
                          logic [16:0] exp);
      @(negedge clk);
      rst = r; opcode = op; zero = z; mem_ready = mr;
      #1;
      check(name, 32'(dut_word()), 32'(exp));
   endtask

   task automatic cyc(string name, logic [6:0] op, logic z, logic mr, int st);
      cyc_exp(name, 1'b0, op, z, mr, ctl(st, mr, z, 1'b0));
   endtask

   task automatic add(string name, logic r, logic [6:0] op, logic z, logic mr,
                      int st, logic ill);
      vec_t v;
      v.name = name; v.rst = r; v.op = op; v.z = z; v.mr = mr;
      v.exp  = ctl(st, mr, z, ill);
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      model_ret = 32'd0;
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_retired", retired, 32'd0);
      check("reset_illegal", 32'(illegal), 32'd0);
   endtask

   // Instruction-level model: expected state trace from class, stalls and zero.
   task automatic run_instr(int cls, int fs, int ms, logic z);
      logic [6:0] op;
      case (cls)
         0:       op = C_R;
         1:       op = C_LD;
         2:       op = C_ST;
         default: op = C_BR;
      endcase
      for (int i = 0; i < fs; i++) cyc("fetch_wait", op, 1'($urandom), 1'b0, 0);
      cyc("fetch", op, 1'($urandom), 1'b1, 0);
      cyc("decode", op, 1'($urandom), 1'($urandom), 1);
      case (cls)
         0: begin
            cyc("exec_r", op, 1'($urandom), 1'($urandom), 2);
            cyc("wb_r", op, 1'($urandom), 1'($urandom), 6);
         end
         1: begin
            cyc("addr_ld", op, 1'($urandom), 1'($urandom), 3);
            for (int i = 0; i < ms; i++) cyc("mem_rd_wait", op, 1'($urandom), 1'b0, 4);
            cyc("mem_rd", op, 1'($urandom), 1'b1, 4);
            cyc("wb_mem", op, 1'($urandom), 1'($urandom), 7);
         end
         2: begin
            cyc("addr_st", op, 1'($urandom), 1'($urandom), 3);
            for (int i = 0; i < ms; i++) cyc("mem_wr_wait", op, 1'($urandom), 1'b0, 5);
            cyc("mem_wr", op, 1'($urandom), 1'b1, 5);
         end
         default: cyc("branch", op, z, 1'($urandom), 8);
      endcase
      model_ret = model_ret + 32'd1;
      @(posedge clk);
      #1;
      check("retired", retired, exp_ret(model_ret));
      check("back_to_fetch", 32'(state_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
      model_ret = 32'd0;
      do_reset();

      // R-type, all memory ready.
      add("r_fetch",  0, C_R, 0, 1, 0, 0);
      add("r_decode", 0, C_R, 0, 1, 1, 0);
      add("r_exec",   0, C_R, 0, 1, 2, 0);
      add("r_wb",     0, C_R, 0, 1, 6, 0);
      // Load with two stall cycles in MEM_RD.
      add("ld_fetch", 0, C_LD, 0, 1, 0, 0);
      add("ld_decode",0, C_LD, 0, 1, 1, 0);
      add("ld_addr",  0, C_LD, 0, 1, 3, 0);
      add("ld_stall1",0, C_LD, 0, 0, 4, 0);
      add("ld_stall2",0, C_LD, 0, 0, 4, 0);
      add("ld_mem",   0, C_LD, 0, 1, 4, 0);
      add("ld_wb",    0, C_LD, 0, 1, 7, 0);
      // Branches taken and not taken.
      add("bt_fetch", 0, C_BR, 1, 1, 0, 0);
      add("bt_decode",0, C_BR, 1, 1, 1, 0);
      add("bt_branch",0, C_BR, 1, 1, 8, 0);
      add("bn_fetch", 0, C_BR, 0, 1, 0, 0);
      add("bn_decode",0, C_BR, 0, 1, 1, 0);
      add("bn_branch",0, C_BR, 0, 1, 8, 0);
      // Store, then a store interrupted by reset while waiting.
      add("st_fetch", 0, C_ST, 0, 1, 0, 0);
      add("st_decode",0, C_ST, 0, 1, 1, 0);
      add("st_addr",  0, C_ST, 0, 1, 3, 0);
      add("st_mem",   0, C_ST, 0, 1, 5, 0);
      add("sr_fetch", 0, C_ST, 0, 1, 0, 0);
      add("sr_decode",0, C_ST, 0, 1, 1, 0);
      add("sr_addr",  0, C_ST, 0, 1, 3, 0);
      add("sr_rst",   1, C_ST, 0, 0, 5, 0);
      add("sr_after", 0, C_ST, 0, 0, 0, 0);
      // Illegal opcode: terminal for 20 cycles, then cleared by reset.
      add("il_fetch", 0, C_BAD, 0, 1, 0, 0);
      add("il_decode",0, C_BAD, 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) add("il_hold", 0, C_R, 1'(i), 1'(i >> 1), 9, 1);
      add("il_rst",   1, C_R, 0, 0, 9, 1);
      add("il_after", 0, C_R, 0, 0, 0, 0);

      foreach (vecs[i]) cyc_exp(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].z,
                                vecs[i].mr, vecs[i].exp);
      check("il_retired_cleared", retired, 32'd0);

      // Mixed workload: 3 R-type, 1 load, 1 store, 1 branch.
      do_reset();
      run_instr(0, 0, 0, 1'b0);
      run_instr(0, 1, 0, 1'b0);
      run_instr(0, 0, 0, 1'b0);
      run_instr(1, 0, 1, 1'b0);
      run_instr(2, 0, 2, 1'b0);
      run_instr(3, 0, 0, 1'b1);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("perf_six", retired, 32'd6);
`else
      check("perf_off", retired, 32'd0);
`endif

      // Randomized instruction stream against the model.
      do_reset();
      for (int n = 0; n < 60; n++)
         run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, both single-bit inputs.
REQ-002 Ports SHALL be, in this order:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  opcode  in  7  instruction[6:0] from the instruction register
  zero  in  1  ALU zero flag
  mem_ready  in  1  memory completes the current access this cycle
  pc_write  out  1  load PC
  pc_src  out  1  0 = PC+4, 1 = branch target
  ir_write  out  1  load instruction register
  i_or_d  out  1  memory address source: 0 = PC, 1 = ALU result
  MemRead  out  1  memory read request
  MemWrite  out  1  memory write request
  RegWrite  out  1  register-file write
  MemToReg  out  1  write-back source: 1 = memory data
  ALUSrc  out  1  ALU operand B: 1 = immediate
  Branch  out  1  branch compare cycle
  ALUop  out  2  0 = add, 1 = subtract/compare, 2 = funct decode
  illegal  out  1  sticky illegal-opcode flag
  state_o  out  4  current state encoding
  retired  out  32  retired-instruction count (macro-gated, REQ-020)

Function
REQ-003 The block SHALL be a Moore FSM with one state register updated on rising clk; outputs SHALL decode from the state, except ir_write, pc_write and pc_src, which also qualify on mem_ready or zero.
REQ-004 States and encodings: FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_MEM=7, BRANCH=8, ILLEGAL=9.
REQ-005 Any output not listed for the current state SHALL be 0.
REQ-006 FETCH SHALL behave as follows:
  - outputs: MemRead=1, i_or_d=0.
  - mem_ready=0: remain in FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
REQ-007 DECODE SHALL select the next state from opcode:
  - 0110011 -> EXEC_R
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other value -> ILLEGAL
REQ-008 DECODE SHALL latch opcode[5] internally as is_store for use in the following states.
REQ-009 EXEC_R SHALL output ALUop=2 and ALUSrc=0, then go to WB_R.
REQ-010 WB_R SHALL output RegWrite=1 and MemToReg=0, then go to FETCH.
REQ-011 ADDR SHALL output ALUop=0 and ALUSrc=1, then go to MEM_WR if is_store=1, else MEM_RD.
REQ-012 MEM_RD SHALL output MemRead=1 and i_or_d=1, and hold until mem_ready=1, then go to WB_MEM.
REQ-013 WB_MEM SHALL output RegWrite=1 and MemToReg=1, then go to FETCH.
REQ-014 MEM_WR SHALL output MemWrite=1 and i_or_d=1, and hold until mem_ready=1, then go to FETCH.
REQ-015 BRANCH SHALL output ALUop=1, ALUSrc=0, Branch=1 and pc_src=1, with pc_write=zero, then go to FETCH.
REQ-016 ILLEGAL SHALL be terminal until rst; illegal SHALL be set on entry to ILLEGAL and SHALL stay 1.
REQ-017 MemRead and MemWrite SHALL never be 1 in the same cycle; request outputs SHALL stay stable while waiting on mem_ready.
REQ-018 Unencoded state values (10-15) SHALL go to FETCH on the next clk.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL on the next cycle have:
  - state=FETCH, illegal=0, is_store=0, retired=0.
  - outputs per FETCH: MemRead=1, all other outputs 0.
  - rst SHALL override any state, including a pending memory wait.

Configuration
REQ-020 Macro MULTICYCLE_CTRL_PERF_EN SHALL control the retired-instruction counter:
  - Defined: retired SHALL increment by 1, wrapping modulo 2^32, on each transition into FETCH from WB_R, WB_MEM, MEM_WR or BRANCH.
  - Undefined: retired SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-021 A shared package mc_ctrl_pkg SHALL hold:
  - state encoding constants
  - opcode constants OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011
  - ALUop constants
REQ-022 The existing main-control opcode decoder SHALL NOT be instantiated; the block SHALL be a single module with no sub-modules.

Verification
REQ-023 R-type: opcode=0110011 with mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R; RegWrite=1 in cycle 4 only; FETCH again in cycle 5.
REQ-024 Load with stall: opcode=0000011, mem_ready low for the first 2 MEM_RD cycles -> MEM_RD held for 3 cycles with MemRead=1 and i_or_d=1; WB_MEM has MemToReg=1; 7 cycles total.
REQ-025 Branch: opcode=1100011 with zero=1 -> pc_write=1 and pc_src=1 in cycle 3; with zero=0 -> pc_write=0 in cycle 3; both return to FETCH.
REQ-026 Illegal opcode: opcode=0010011 -> state_o=9 and illegal=1 from cycle 3, held for 20 cycles; rst then gives state_o=0 and illegal=0.
REQ-027 Reset mid-store: rst asserted during MEM_WR with mem_ready=0 -> next cycle state_o=0, MemWrite=0, MemRead=1.
REQ-028 Perf counter: with MULTICYCLE_CTRL_PERF_EN defined, 3 R-type, 1 load, 1 store and 1 branch -> retired=6; without the macro -> retired=0.
